tdc_readout: RTL and testbench
==============================

TDC_READOUT -- requirements
Module: tdc_readout

Interface
REQ-001 SHALL have parameter W, default 32, giving the TDC result word width, legal range 8..64.
REQ-002 SHALL have parameter DEPTH, default 8, giving the FIFO depth in words, a power of two from 2 to 64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port iRst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port iTDC, input, W bits: the measured word from the TDC stage.
REQ-006 SHALL have port iDone, input, 1 bit: a one-cycle strobe meaning iTDC is valid this cycle.
REQ-007 SHALL have port iReady, input, 1 bit: the byte sink is ready (UART TX side).
REQ-008 SHALL have port oByte, output, 8 bits: the serialized frame byte.
REQ-009 SHALL have port oValid, output, 1 bit: oByte is valid.
REQ-010 SHALL have port oEmpty, output, 1 bit: the FIFO holds 0 words.
REQ-011 SHALL have port oFull, output, 1 bit: the FIFO holds DEPTH words.
REQ-012 SHALL have port oDropped, output, 8 bits: a saturating count of words lost to overflow.

Function
REQ-013 SHALL define NB = ceil(W/8); each word is zero-padded in its MSBs to NB*8 bits.
REQ-014 SHALL write iTDC into the FIFO on a rising clk edge where iDone=1 and oFull=0; the FIFO count is visible on the next cycle.
REQ-015 SHALL, when iDone=1 and oFull=1 (the count before the edge), discard the word and increment oDropped, saturating at 0xFF; this holds even if a pop occurs in the same cycle.
REQ-016 SHALL implement the FSM states IDLE, SYNC, DATA, and CSUM (CSUM only with the macro, see REQ-028).
REQ-017 SHALL, in IDLE with oEmpty=0, pop the head word into a shift register and move to SYNC on the next edge; the pop and the write of REQ-014 may coincide.
REQ-018 SHALL, in SYNC, drive oValid=1 and oByte=0xA5; on oValid&iReady it moves to DATA with a byte index of 0.
REQ-019 SHALL, in DATA, drive oByte with byte NB-1-index of the padded word (MSB first); each handshake increments the index.
REQ-020 SHALL, on the handshake of the last data byte, go to CSUM if enabled, else to IDLE.
REQ-021 SHALL keep oByte and oValid registered and hold them stable while iReady=0; there is no combinational path from iReady to oValid.
REQ-022 SHALL drive oValid=0 in IDLE; the minimum gap between frames is one IDLE cycle.
REQ-023 SHALL have a latency of 2 cycles from the iDone edge to oValid=1 (SYNC) when idle with an empty FIFO.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH; oEmpty and oFull are derived from a count of width log2(DEPTH)+1.

Reset
REQ-025 SHALL, on iRst=1, immediately force state=IDLE, FIFO count=0, pointers=0, oValid=0, oByte=0x00, oDropped=0, oEmpty=1, oFull=0.
REQ-026 SHALL abandon any frame in flight on a reset mid-frame, with no partial completion after release.
REQ-027 SHALL ignore iDone while iRst=1.

Configuration
REQ-028 SHALL use macro TDC_READOUT_CHECKSUM_EN: when defined, CSUM follows DATA and outputs the XOR of the NB data bytes (0xA5 excluded), then returns to IDLE on handshake; the frame length is NB+2.
REQ-029 SHALL, when TDC_READOUT_CHECKSUM_EN is undefined, contain no CSUM state or XOR logic; the frame length is NB+1.

Verification
REQ-030 SHALL test W=32 with no macro and iReady=1: iDone with 0x12345678 -> bytes A5,12,34,56,78 on consecutive cycles, oValid first high 2 cycles after iDone.
REQ-031 SHALL test W=32 with TDC_READOUT_CHECKSUM_EN: the same word -> A5,12,34,56,78,08.
REQ-032 SHALL test backpressure: iReady toggling 1/0 each cycle -> oByte stable during iReady=0, byte sequence unchanged, no duplicates.
REQ-033 SHALL test overflow with DEPTH=8 and iReady=0: 10 iDone pulses spaced 4 cycles apart -> word 1 in the shift register, words 2-9 in the FIFO, oFull=1, oDropped=1; then iReady=1 -> 9 complete frames in order.
REQ-034 SHALL test W=12: 0xABC -> A5,0A,BC (padding check).
REQ-035 SHALL test reset mid-DATA after 2 bytes: assert iRst for 1 cycle -> oValid=0 asynchronously, oEmpty=1, and no bytes after release until the next iDone.

Source files
------------

// File: rtl/tdc_readout.sv
// tdc_readout: buffers TDC result words in a small FIFO and serializes each
// one as a byte frame for a UART-style sink: 0xA5, then the zero-padded word
// MSB first. Optional macro TDC_READOUT_CHECKSUM_EN appends the XOR of the
// data bytes as a final frame byte.
module tdc_readout #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         iRst,
  input  logic [W-1:0] iTDC,
  input  logic         iDone,
  input  logic         iReady,
  output logic [7:0]   oByte,
  output logic         oValid,
  output logic         oEmpty,
  output logic         oFull,
  output logic [7:0]   oDropped
);

  localparam int NB = (W + 7) / 8;
  localparam int SW = NB * 8;
  localparam int AW = $clog2(DEPTH);

`ifdef TDC_READOUT_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic [7:0]    dropped_q, dropped_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          wr_en_s, pop_s, hs_s;
`ifdef TDC_READOUT_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  // FIFO bookkeeping: write/pop decisions, pointers, count, flags, drop counter
  always_comb begin
    wr_en_s = iDone && !full_q;
    pop_s   = (state_q == IDLE) && !empty_q;
    wptr_d  = wr_en_s ? wptr_q + {{(AW-1){1'b0}}, 1'b1} : wptr_q;
    rptr_d  = pop_s ? rptr_q + {{(AW-1){1'b0}}, 1'b1} : rptr_q;
    count_d = count_q + {{AW{1'b0}}, wr_en_s} - {{AW{1'b0}}, pop_s};
    empty_d = (count_d == {(AW+1){1'b0}});
    full_d  = (count_d == (AW+1)'(DEPTH));
    if (iDone && full_q && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end else begin
      dropped_d = dropped_q;
    end
  end

  // Frame sequencer: next state plus the next registered byte/valid values
  always_comb begin
    hs_s    = valid_q && iReady;
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    valid_d = valid_q;
`ifdef TDC_READOUT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pop_s) begin
          sr_d         = '0;
          sr_d[W-1:0]  = mem_q[rptr_q];
          state_d      = SYNC;
          valid_d      = 1'b1;
          byte_d       = 8'hA5;
`ifdef TDC_READOUT_CHECKSUM_EN
          csum_d       = 8'h00;
`endif
        end
      end
      SYNC: begin
        if (hs_s) begin
          state_d = DATA;
          idx_d   = 4'd0;
          byte_d  = sr_q[SW-1 -: 8];
          sr_d    = sr_q << 8;
`ifdef TDC_READOUT_CHECKSUM_EN
          csum_d  = csum_q ^ sr_q[SW-1 -: 8];
`endif
        end
      end
      DATA: begin
        if (hs_s) begin
          if (idx_q == 4'(NB - 1)) begin
`ifdef TDC_READOUT_CHECKSUM_EN
            // csum_q already covers every data byte, including the one just sent
            state_d = CSUM;
            byte_d  = csum_q;
`else
            state_d = IDLE;
            valid_d = 1'b0;
`endif
          end else begin
            idx_d   = idx_q + 4'd1;
            byte_d  = sr_q[SW-1 -: 8];
            sr_d    = sr_q << 8;
`ifdef TDC_READOUT_CHECKSUM_EN
            csum_d  = csum_q ^ sr_q[SW-1 -: 8];
`endif
          end
        end
      end
`ifdef TDC_READOUT_CHECKSUM_EN
      CSUM: begin
        if (hs_s) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // FIFO storage; pointers reset, so stale contents are never observed
  always_ff @(posedge clk) begin
    if (wr_en_s && !iRst) begin
      mem_q[wptr_q] <= iTDC;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      dropped_q <= 8'h00;
      sr_q      <= '0;
      idx_q     <= 4'd0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
`ifdef TDC_READOUT_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      dropped_q <= dropped_d;
      sr_q      <= sr_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
`ifdef TDC_READOUT_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign oByte    = byte_q;
  assign oValid   = valid_q;
  assign oEmpty   = empty_q;
  assign oFull    = full_q;
  assign oDropped = dropped_q;

endmodule

// File: tb/tb_tdc_readout.sv
// Scoreboard bench for tdc_readout: a W=32 and a W=12 instance, expected
// frames queued at stimulus time, monitors pop on every handshake.
module tb_tdc_readout;

`ifdef TDC_READOUT_CHECKSUM_EN
  localparam int FLEN32 = 6;
`else
  localparam int FLEN32 = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iTDC;
  logic        iDone, iReady;
  logic [7:0]  oByte, oDropped;
  logic        oValid, oEmpty, oFull;
  logic [11:0] iTDC12;
  logic        iDone12, iReady12;
  logic [7:0]  oByte12, oDropped12;
  logic        oValid12, oEmpty12, oFull12;

  int errors = 0;
  int checks = 0;
  logic [7:0] q32[$];
  logic [7:0] q12[$];
  logic       held32_v = 1'b0;
  logic [7:0] held32_b = 8'h00;

  always #5 clk = ~clk;

  tdc_readout #(.W(32), .DEPTH(8)) u_dut (
    .clk(clk), .iRst(rst), .iTDC(iTDC), .iDone(iDone), .iReady(iReady),
    .oByte(oByte), .oValid(oValid), .oEmpty(oEmpty), .oFull(oFull), .oDropped(oDropped)
  );

  tdc_readout #(.W(12), .DEPTH(8)) u_dut12 (
    .clk(clk), .iRst(rst), .iTDC(iTDC12), .iDone(iDone12), .iReady(iReady12),
    .oByte(oByte12), .oValid(oValid12), .oEmpty(oEmpty12), .oFull(oFull12), .oDropped(oDropped12)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame32(input logic [31:0] w);
    logic [7:0] x;
    x = 8'h00;
    q32.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) begin
      q32.push_back(w[i*8 +: 8]);
      x = x ^ w[i*8 +: 8];
    end
`ifdef TDC_READOUT_CHECKSUM_EN
    q32.push_back(x);
`endif
  endtask

  // Monitor for the W=32 instance: byte order plus hold-under-backpressure
  always @(negedge clk) begin
    if (rst) begin
      held32_v = 1'b0;
    end else begin
      if (held32_v && oValid) check("hold32", {56'd0, oByte}, {56'd0, held32_b});
      if (oValid && iReady) begin
        if (q32.size() == 0) check("unexpected_valid32", {63'd0, oValid}, 64'd0);
        else check("byte32", {56'd0, oByte}, {56'd0, q32.pop_front()});
      end
      held32_v = oValid && !iReady;
      held32_b = oByte;
    end
  end

  // Monitor for the W=12 instance
  always @(negedge clk) begin
    if (!rst && oValid12 && iReady12) begin
      if (q12.size() == 0) check("unexpected_valid12", {63'd0, oValid12}, 64'd0);
      else check("byte12", {56'd0, oByte12}, {56'd0, q12.pop_front()});
    end
  end

  task automatic drain32(input int budget);
    int n;
    n = 0;
    while (q32.size() != 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check("drain32", q32.size(), 64'd0);
  endtask

  task automatic pulse32(input logic [31:0] w, input bit accepted);
    @(posedge clk); #1;
    iTDC = w; iDone = 1'b1;
    if (accepted) push_frame32(w);
    @(posedge clk); #1;
    iDone = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; iTDC = 32'd0; iDone = 1'b0; iReady = 1'b1;
    iTDC12 = 12'd0; iDone12 = 1'b0; iReady12 = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_valid", {63'd0, oValid}, 64'd0);
    check("rst_byte", {56'd0, oByte}, 64'd0);
    check("rst_empty", {63'd0, oEmpty}, 64'd1);
    check("rst_full", {63'd0, oFull}, 64'd0);
    check("rst_dropped", {56'd0, oDropped}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single frame, latency and back-to-back bytes
    @(posedge clk); #1;
    iTDC = 32'h12345678; iDone = 1'b1; push_frame32(32'h12345678);
    @(posedge clk); #1;
    iDone = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", {63'd0, oValid}, 64'd0);
    check("lat_cycle1_empty", {63'd0, oEmpty}, 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", {63'd0, oValid}, 64'd1);
    check("sync_byte", {56'd0, oByte}, 64'hA5);
    repeat (FLEN32) @(negedge clk);
    #1;
    check("gap_valid", {63'd0, oValid}, 64'd0);
    check("consecutive", q32.size(), 64'd0);

    // Padding with W=12
    @(posedge clk); #1;
    iTDC12 = 12'hABC; iDone12 = 1'b1;
    q12.push_back(8'hA5); q12.push_back(8'h0A); q12.push_back(8'hBC);
`ifdef TDC_READOUT_CHECKSUM_EN
    q12.push_back(8'hB6);
`endif
    @(posedge clk); #1;
    iDone12 = 1'b0;
    n = 0;
    while (q12.size() != 0 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("drain12", q12.size(), 64'd0);

    // Backpressure: iReady toggling every cycle
    @(posedge clk); #1;
    iTDC = 32'hDEADBEEF; iDone = 1'b1; push_frame32(32'hDEADBEEF);
    @(posedge clk); #1;
    iDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      iReady = ~iReady;
      @(posedge clk); #1;
    end
    iReady = 1'b1;
    drain32(50);

    // Reset in the middle of the data bytes
    @(posedge clk); #1;
    iTDC = 32'hCAFEF00D; iDone = 1'b1; push_frame32(32'hCAFEF00D);
    @(posedge clk); #1;
    iDone = 1'b0;
    n = 0;
    while (q32.size() != FLEN32 - 3 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("mid_frame_reached", q32.size(), FLEN32 - 3);
    @(posedge clk); #1;
    rst = 1'b1;
    q32.delete();
    #1;
    check("rst_async_valid", {63'd0, oValid}, 64'd0);
    check("rst_async_empty", {63'd0, oEmpty}, 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_quiet", {63'd0, oValid}, 64'd0);

    // Overflow with the sink stalled
    iReady = 1'b0;
    for (int i = 1; i <= 10; i++) pulse32(32'hA0B0C000 | i, i <= 9);
    @(negedge clk);
    check("ovf_full", {63'd0, oFull}, 64'd1);
    check("ovf_dropped", {56'd0, oDropped}, 64'd1);
    check("ovf_valid_held", {63'd0, oValid}, 64'd1);
    check("ovf_byte_held", {56'd0, oByte}, 64'hA5);
    @(posedge clk); #1 iReady = 1'b1;
    drain32(300);
    repeat (3) @(negedge clk);
    check("end_empty", {63'd0, oEmpty}, 64'd1);
    check("end_full", {63'd0, oFull}, 64'd0);
    check("end_dropped", {56'd0, oDropped}, 64'd1);
    check("end_valid", {63'd0, oValid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
